// File: rtl/hoval_pkg.sv
// Shared constants and state encodings for the OUT1 stream checker.
// Imported by the checker top and its RAM sub-module.
package hoval_pkg;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PASS = 2'b10,
    ST_FAIL = 2'b11
  } state_e;

endpackage

// File: rtl/hoval_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-first: a same-address write in the read cycle returns old data.
module hoval_sdp_ram
  import hoval_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/hoval_out_checker.sv
// Logs OUT1 writes and compares them in order against a host-loaded
// expected stream, producing a sticky PASS/FAIL verdict and halt request.
module hoval_out_checker
  import hoval_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W:0]   exp_len,
  input  logic              arm,
  input  logic              out_strobe,
  input  logic [DATA_W-1:0] out_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   mismatch_idx,
  output logic              halt_req
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   mis_q, mis_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              v1_q, v1_d;
  logic [DATA_W-1:0] exp_rd;
  logic              full, accept, log_we;
  logic              extra, bad;

  // count saturates at 2**ADDR_W, so the MSB alone marks "full"
  assign full   = count_q[ADDR_W];
  assign accept = out_strobe & ~arm & (state_q != ST_IDLE);
  assign log_we = accept & ~full;
  assign extra  = (idx_q >= len_q);
  assign bad    = extra | (data_q != exp_rd);

  hoval_sdp_ram #(
    .DW(DATA_W),
    .AW(ADDR_W)
  ) u_log (
    .clk    (clk),
    .we_i   (log_we),
    .waddr_i(count_q[ADDR_W-1:0]),
    .wdata_i(out_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  hoval_sdp_ram #(
    .DW(DATA_W),
    .AW(ADDR_W)
  ) u_exp (
    .clk    (clk),
    .we_i   (exp_we),
    .waddr_i(exp_addr),
    .wdata_i(exp_data),
    .raddr_i(count_q[ADDR_W-1:0]),
    .rdata_o(exp_rd)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mis_d   = mis_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    v1_d    = 1'b0;

    if (v1_q && (state_q != ST_FAIL)) begin
      if (bad) begin
        state_d = ST_FAIL;
        mis_d   = idx_q;
      end else if (idx_q + ONE == len_q) begin
        state_d = ST_PASS;
      end
    end

    if (accept) begin
      idx_d  = count_q;
      data_d = out_data;
      v1_d   = 1'b1;
      if (!full) begin
        count_d = count_q + ONE;
      end
    end

    // arm overrides both the in-flight compare and a same-cycle strobe
    if (arm) begin
      count_d = '0;
      mis_d   = '0;
      len_d   = exp_len;
      v1_d    = 1'b0;
      state_d = (exp_len == '0) ? ST_PASS : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      mis_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      v1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mis_q   <= mis_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      v1_q    <= v1_d;
    end
  end

  assign count        = count_q;
  assign state        = state_q;
  assign mismatch_idx = mis_q;
  assign halt_req     = (state_q == ST_PASS) || (state_q == ST_FAIL);

endmodule
